// File: rtl/alu_exec_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Execute-stage ALU with a two-stage pipeline and valid/ready handshakes on
// both sides.
//   S1 captures the operands, op code and destination index of an accepted
//      packet.
//   S2 captures the ALU result, zero flag, illegal-op flag and destination
//      index. It holds them stable until the downstream side accepts them.
// A flush empties both stages. A saturating counter tracks how many results
// have been handed off downstream.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   flush        discard every in-flight packet (branch mispredict)
//   in_valid     upstream packet valid
//   in_ready     unit can accept a packet this cycle
//   in_op        ALU op: ADD, SUB, AND, OR, XOR, SLT (signed); 110/111 reserved
//   in_a, in_b   operands
//   in_rd        destination register index
//   out_valid    result packet valid
//   out_ready    downstream accepts the result
//   out_result   ALU result
//   out_zero     out_result == 0
//   out_illegal  packet carried a reserved op
//   out_rd       destination index travelling with the packet
//   op_count     saturating count of completed handoffs
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RDW  = 5,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [RDW-1:0]  in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            out_illegal,
    output logic [RDW-1:0]  out_rd,
    output logic [CNTW-1:0] op_count
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101
    } alu_op_e;

    // -----------------------------------------------------------------
    // Stage 1: operand registers
    // -----------------------------------------------------------------
    logic            s1_valid_q, s1_valid_d;
    logic [XLEN-1:0] s1_a_q,     s1_a_d;
    logic [XLEN-1:0] s1_b_q,     s1_b_d;
    logic [2:0]      s1_op_q,    s1_op_d;
    logic [RDW-1:0]  s1_rd_q,    s1_rd_d;

    // -----------------------------------------------------------------
    // Stage 2: result registers (drive out_* directly)
    // -----------------------------------------------------------------
    logic            s2_valid_q,   s2_valid_d;
    logic [XLEN-1:0] s2_result_q,  s2_result_d;
    logic            s2_zero_q,    s2_zero_d;
    logic            s2_illegal_q, s2_illegal_d;
    logic [RDW-1:0]  s2_rd_q,      s2_rd_d;

    // Completed-operation counter
    logic [CNTW-1:0] cnt_q, cnt_d;

    // -----------------------------------------------------------------
    // Stage control
    // -----------------------------------------------------------------
    logic s2_free;
    logic s1_adv;
    logic in_fire;
    logic handoff;

    // in_ready depends on out_ready combinationally so that a full pipe
    // whose head is leaving this cycle can still accept a new packet.
    assign s2_free  = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s1_adv;
    assign in_fire  = in_valid && in_ready;
    assign handoff  = s2_valid_q && out_ready;

    // -----------------------------------------------------------------
    // ALU, evaluated on the S1 contents
    // -----------------------------------------------------------------
    logic [XLEN-1:0] alu_result;
    logic            alu_illegal;
    logic            alu_slt;

    assign alu_slt = ($signed(s1_a_q) < $signed(s1_b_q));

    always_comb begin
        alu_result  = '0;
        alu_illegal = 1'b0;
        case (s1_op_q)
            OP_ADD:  alu_result = s1_a_q + s1_b_q;
            OP_SUB:  alu_result = s1_a_q - s1_b_q;
            OP_AND:  alu_result = s1_a_q & s1_b_q;
            OP_OR:   alu_result = s1_a_q | s1_b_q;
            OP_XOR:  alu_result = s1_a_q ^ s1_b_q;
            OP_SLT:  alu_result = XLEN'(alu_slt);
            // Reserved ops still travel through the pipe and get counted;
            // they only carry a zero result and the illegal flag.
            default: begin
                alu_result  = '0;
                alu_illegal = 1'b1;
            end
        endcase
    end

    // -----------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_op_d      = s1_op_q;
        s1_rd_d      = s1_rd_q;
        s2_valid_d   = s2_valid_q;
        s2_result_d  = s2_result_q;
        s2_zero_d    = s2_zero_q;
        s2_illegal_d = s2_illegal_q;
        s2_rd_d      = s2_rd_q;
        cnt_d        = cnt_q;

        if (flush) begin
            // Drops everything, including a stalled S2 and any packet
            // offered this cycle. Data registers keep stale contents;
            // they are qualified by the cleared valids.
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s2_free) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    s2_result_d  = alu_result;
                    s2_zero_d    = (alu_result == '0);
                    s2_illegal_d = alu_illegal;
                    s2_rd_d      = s1_rd_q;
                end
            end
            if (in_ready) begin
                s1_valid_d = in_valid;
                if (in_fire) begin
                    s1_a_d  = in_a;
                    s1_b_d  = in_b;
                    s1_op_d = in_op;
                    s1_rd_d = in_rd;
                end
            end
        end

        // A handoff in a flush cycle still completes, so the counter is
        // outside the flush branch.
        if (handoff && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    // -----------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_op_q      <= '0;
            s1_rd_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= '0;
            s2_zero_q    <= 1'b0;
            s2_illegal_q <= 1'b0;
            s2_rd_q      <= '0;
            cnt_q        <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_op_q      <= s1_op_d;
            s1_rd_q      <= s1_rd_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_zero_q    <= s2_zero_d;
            s2_illegal_q <= s2_illegal_d;
            s2_rd_q      <= s2_rd_d;
            cnt_q        <= cnt_d;
        end
    end

    // -----------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------
    assign out_valid   = s2_valid_q;
    assign out_result  = s2_result_q;
    assign out_zero    = s2_zero_q;
    assign out_illegal = s2_illegal_q;
    assign out_rd      = s2_rd_q;
    assign op_count    = cnt_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Two instances share the same stimulus: the default CNTW=16 unit and a
// CNTW=4 unit whose counter saturates during the run. A queue-based model
// tracks the packets in flight by their acceptance cycle and predicts
// in_ready, out_valid, result fields and op_count every cycle. Each packet
// also carries a hand-computed expected result that is checked when it
// leaves.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_rd;
    logic        out_ready;

    logic        in_ready16,  in_ready4;
    logic        out_valid16, out_valid4;
    logic [31:0] out_result16, out_result4;
    logic        out_zero16,  out_zero4;
    logic        out_illegal16, out_illegal4;
    logic [4:0]  out_rd16, out_rd4;
    logic [15:0] op_count16;
    logic [3:0]  op_count4;

    // Hand-computed expectation travelling with the packet being offered
    logic [31:0] lit_res;
    logic        lit_ill;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_exec_unit u_dut16 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready16),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
        .out_valid(out_valid16), .out_ready(out_ready),
        .out_result(out_result16), .out_zero(out_zero16),
        .out_illegal(out_illegal16), .out_rd(out_rd16),
        .op_count(op_count16)
    );

    alu_exec_unit #(.CNTW(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_result(out_result4), .out_zero(out_zero4),
        .out_illegal(out_illegal4), .out_rd(out_rd4),
        .op_count(op_count4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // ---------------------------------------------------------------
    // Model and per-cycle compare
    // ---------------------------------------------------------------
    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          acc;
        logic [31:0] lres;
        logic        lill;
    } pkt_t;

    pkt_t pipe_q[$];
    int   cyc   = 0;
    int   cnt16 = 0;
    int   cnt4  = 0;
    bit   known = 1'b0;

    always @(negedge clk) begin
        bit          m_ov, m_s1, m_ir, in_fire, out_fire;
        logic [31:0] r;
        pkt_t        p;
        m_ov = (pipe_q.size() > 0) && (pipe_q[0].acc + 2 <= cyc);
        m_s1 = (pipe_q.size() == 2) || ((pipe_q.size() == 1) && (pipe_q[0].acc + 1 == cyc));
        m_ir = !m_s1 || !m_ov || (out_ready === 1'b1);
        if (known) begin
            chk("in_ready16",  32'(in_ready16),  32'(m_ir));
            chk("in_ready4",   32'(in_ready4),   32'(m_ir));
            chk("out_valid16", 32'(out_valid16), 32'(m_ov));
            chk("out_valid4",  32'(out_valid4),  32'(m_ov));
            chk("op_count16",  32'(op_count16),  32'(cnt16));
            chk("op_count4",   32'(op_count4),   32'(cnt4));
            if (m_ov) begin
                r = model_res(pipe_q[0].op, pipe_q[0].a, pipe_q[0].b);
                chk("result16",  out_result16,        r);
                chk("result4",   out_result4,         r);
                chk("zero16",    32'(out_zero16),     32'(r == 32'd0));
                chk("illegal16", 32'(out_illegal16),  32'(pipe_q[0].op > 3'd5));
                chk("rd16",      32'(out_rd16),       32'(pipe_q[0].rd));
                chk("rd4",       32'(out_rd4),        32'(pipe_q[0].rd));
            end
        end
        if (rst === 1'b1) begin
            pipe_q.delete();
            cnt16 = 0;
            cnt4  = 0;
            known = 1'b1;
        end else if (known) begin
            in_fire  = (in_valid === 1'b1) && m_ir;
            out_fire = m_ov && (out_ready === 1'b1);
            if (out_fire) begin
                chk("lit_result",  out_result16,        pipe_q[0].lres);
                chk("lit_zero",    32'(out_zero16),     32'(pipe_q[0].lres == 32'd0));
                chk("lit_illegal", 32'(out_illegal16),  32'(pipe_q[0].lill));
                void'(pipe_q.pop_front());
                if (cnt16 < 65535) cnt16++;
                if (cnt4  < 15)    cnt4++;
            end
            if (flush === 1'b1) begin
                pipe_q.delete();
            end else if (in_fire) begin
                p.op = in_op; p.a = in_a; p.b = in_b; p.rd = in_rd;
                p.acc = cyc; p.lres = lit_res; p.lill = lit_ill;
                pipe_q.push_back(p);
            end
        end
        cyc++;
    end

    // ---------------------------------------------------------------
    // Stimulus helpers (inputs change 1ns after the rising edge)
    // ---------------------------------------------------------------
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] lres, input logic lill);
        bit acc = 1'b0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd;
        lit_res = lres; lit_ill = lill;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready16;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            total++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0;
        in_a = '0; in_b = '0; in_rd = '0; out_ready = 1'b1;
        lit_res = '0; lit_ill = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid16), 32'd0);
        chk("rst_in_ready",  32'(in_ready16),  32'd1);
        chk("rst_result",    out_result16,     32'd0);
        chk("rst_count",     32'(op_count16),  32'd0);
        @(posedge clk); #1;

        // 1: back-to-back ADD, SUB, SLT
        send(3'd0, 32'd5,          32'd7, 5'd1, 32'd12,         1'b0);
        send(3'd1, 32'd3,          32'd5, 5'd2, 32'hFFFF_FFFE,  1'b0);
        send(3'd5, 32'hFFFF_FFFF,  32'd1, 5'd3, 32'd1,          1'b0);
        idle(4);
        @(negedge clk); chk("t1_count", 32'(op_count16), 32'd3);
        @(posedge clk); #1;

        // 2: zero flag set and clear
        send(3'd1, 32'd9,       32'd9,       5'd4, 32'd0,       1'b0);
        send(3'd4, 32'h0000_F0F0, 32'h0000_0FF0, 5'd5, 32'h0000_FF00, 1'b0);
        idle(4);

        // 3: backpressure for 4 cycles while streaming 3 packets
        fork
            begin
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                send(3'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd6, 32'h0F00_0F00, 1'b0);
                send(3'd3, 32'h0000_00F0, 32'h0000_0F00, 5'd7, 32'h0000_0FF0, 1'b0);
                send(3'd5, 32'd5,         32'hFFFF_FFFD, 5'd8, 32'd0,         1'b0);
            end
        join
        idle(4);
        @(negedge clk); chk("t3_count", 32'(op_count16), 32'd8);
        @(posedge clk); #1;

        // 4: flush with S2 stalled and S1 full; offered packet dropped
        out_ready = 1'b0;
        send(3'd0, 32'd1, 32'd2, 5'd9,  32'd3, 1'b0);
        send(3'd0, 32'd3, 32'd4, 5'd10, 32'd7, 1'b0);
        flush = 1'b1;
        in_valid = 1'b1; in_op = 3'd0; in_a = 32'd50; in_b = 32'd50; in_rd = 5'd11;
        lit_res = 32'd100; lit_ill = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("t4_out_valid", 32'(out_valid16), 32'd0);
        chk("t4_in_ready",  32'(in_ready16),  32'd1);
        chk("t4_count",     32'(op_count16),  32'd8);
        @(posedge clk); #1;
        send(3'd0, 32'd1, 32'd1, 5'd12, 32'd2, 1'b0);
        idle(4);

        // 4b: handoff in the flush cycle still counts; S1 packet dropped
        out_ready = 1'b0;
        send(3'd0, 32'd10, 32'd0, 5'd13, 32'd10, 1'b0);
        send(3'd0, 32'd20, 32'd0, 5'd14, 32'd20, 1'b0);
        out_ready = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        idle(3);
        @(negedge clk); chk("t4b_count", 32'(op_count16), 32'd10);
        @(posedge clk); #1;

        // 5: reserved ops
        send(3'b110, 32'd7, 32'd3, 5'd15, 32'd0, 1'b1);
        send(3'b111, 32'd1, 32'd1, 5'd16, 32'd0, 1'b1);
        idle(4);

        // 6: 20 handoffs; CNTW=4 instance saturates
        for (int i = 0; i < 20; i++) begin
            send(3'd0, 32'(i), 32'd1, 5'(i), 32'(i + 1), 1'b0);
        end
        idle(4);
        @(negedge clk);
        chk("t6_count16", 32'(op_count16), 32'd32);
        chk("t6_count4",  32'(op_count4),  32'd15);
        @(posedge clk); #1;

        // Reset mid-stream
        send(3'd0, 32'd100, 32'd1, 5'd20, 32'd101, 1'b0);
        send(3'd0, 32'd200, 32'd1, 5'd21, 32'd201, 1'b0);
        rst = 1'b1;
        in_valid = 1'b1; in_op = 3'd1; in_a = 32'd9; in_b = 32'd1; in_rd = 5'd22;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rst2_out_valid", 32'(out_valid16),   32'd0);
        chk("rst2_result",    out_result16,       32'd0);
        chk("rst2_zero",      32'(out_zero16),    32'd0);
        chk("rst2_illegal",   32'(out_illegal16), 32'd0);
        chk("rst2_rd",        32'(out_rd16),      32'd0);
        chk("rst2_count16",   32'(op_count16),    32'd0);
        chk("rst2_count4",    32'(op_count4),     32'd0);
        chk("rst2_in_ready",  32'(in_ready16),    32'd1);
        @(posedge clk); #1;
        send(3'd0, 32'd1, 32'd1, 5'd23, 32'd2, 1'b0);
        idle(4);
        @(negedge clk); chk("final_count", 32'(op_count16), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
